// File: rtl/sq1_reg_decoder.sv
// CPU-side register front end for square channel 1: decodes NR10-NR14 and NR52
// byte writes into pulseChannel1 field controls, with masked read-back.
module sq1_reg_decoder #(
  parameter logic [7:0] BASE_ADDR = 8'h10,
  parameter logic [7:0] PWR_ADDR  = 8'h26,
  parameter bit         PWR_RESET = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_en,
  input  logic        rd_en,
  input  logic [7:0]  addr,
  input  logic [7:0]  wdata,
  output logic [7:0]  rdata,
  output logic        rvalid,
  input  logic        ch1_active,
  output logic [2:0]  sq1_swpPd,
  output logic        sq1_negate,
  output logic [2:0]  sq1_shift,
  output logic [1:0]  sq1_duty,
  output logic [5:0]  sq1_lenLoad,
  output logic        sq1_lenLoadStb,
  output logic [3:0]  sq1_startVol,
  output logic        sq1_envAdd,
  output logic [2:0]  sq1_period,
  output logic [10:0] sq1_freq,
  output logic        sq1_lenEnable,
  output logic        sq1_trigger,
  output logic        power
);

  localparam logic [7:0] NR10_ADDR = BASE_ADDR;
  localparam logic [7:0] NR11_ADDR = BASE_ADDR + 8'd1;
  localparam logic [7:0] NR12_ADDR = BASE_ADDR + 8'd2;
  localparam logic [7:0] NR13_ADDR = BASE_ADDR + 8'd3;
  localparam logic [7:0] NR14_ADDR = BASE_ADDR + 8'd4;

  logic [7:0] rd_mux;

  // Read-back reflects the current (pre-write) register state.
  always_comb begin
    // NOTE: default assignment first so every path drives rd_mux and no latch is inferred.
    rd_mux = 8'hFF;
    if (addr == NR10_ADDR)
      rd_mux = {1'b1, sq1_swpPd, sq1_negate, sq1_shift};
    else if (addr == NR11_ADDR)
      rd_mux = {sq1_duty, 6'h3F};
    else if (addr == NR12_ADDR)
      rd_mux = {sq1_startVol, sq1_envAdd, sq1_period};
    else if (addr == NR13_ADDR)
      rd_mux = 8'hFF;
    else if (addr == NR14_ADDR)
      rd_mux = {1'b1, sq1_lenEnable, 6'h3F};
    else if (addr == PWR_ADDR)
      rd_mux = {power, 3'b111, 3'b000, ch1_active & power};
  end

  // NOTE: all state updates use non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata          <= 8'h00;
      rvalid         <= 1'b0;
      sq1_swpPd      <= '0;
      sq1_negate     <= 1'b0;
      sq1_shift      <= '0;
      sq1_duty       <= '0;
      sq1_lenLoad    <= '0;
      sq1_lenLoadStb <= 1'b0;
      sq1_startVol   <= '0;
      sq1_envAdd     <= 1'b0;
      sq1_period     <= '0;
      sq1_freq       <= '0;
      sq1_lenEnable  <= 1'b0;
      sq1_trigger    <= 1'b0;
      power          <= PWR_RESET;
    end else begin
      sq1_trigger    <= 1'b0;
      sq1_lenLoadStb <= 1'b0;
      rvalid         <= rd_en;
      if (rd_en)
        rdata <= rd_mux;

      if (wr_en) begin
        if (addr == PWR_ADDR) begin
          power <= wdata[7];
          // Powering down wipes every channel field; no pulses are emitted.
          if (!wdata[7]) begin
            sq1_swpPd     <= '0;
            sq1_negate    <= 1'b0;
            sq1_shift     <= '0;
            sq1_duty      <= '0;
            sq1_lenLoad   <= '0;
            sq1_startVol  <= '0;
            sq1_envAdd    <= 1'b0;
            sq1_period    <= '0;
            sq1_freq      <= '0;
            sq1_lenEnable <= 1'b0;
          end
        end else if (power) begin
          if (addr == NR10_ADDR) begin
            sq1_swpPd  <= wdata[6:4];
            sq1_negate <= wdata[3];
            sq1_shift  <= wdata[2:0];
          end else if (addr == NR11_ADDR) begin
            sq1_duty       <= wdata[7:6];
            sq1_lenLoad    <= wdata[5:0];
            sq1_lenLoadStb <= 1'b1;
          end else if (addr == NR12_ADDR) begin
            sq1_startVol <= wdata[7:4];
            sq1_envAdd   <= wdata[3];
            sq1_period   <= wdata[2:0];
          end else if (addr == NR13_ADDR) begin
            sq1_freq[7:0] <= wdata;
          end else if (addr == NR14_ADDR) begin
            sq1_freq[10:8] <= wdata[2:0];
            sq1_lenEnable  <= wdata[6];
            sq1_trigger    <= wdata[7];
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_sq1_reg_decoder.sv
// Scoreboard bench for sq1_reg_decoder: a byte-level register model predicts
// fields, pulses and read data; a monitor compares every cycle.
module tb_sq1_reg_decoder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wr_en = 1'b0;
  logic        rd_en = 1'b0;
  logic [7:0]  addr = 8'h00;
  logic [7:0]  wdata = 8'h00;
  logic        ch1_active = 1'b0;
  logic [7:0]  rdata;
  logic        rvalid;
  logic [2:0]  sq1_swpPd;
  logic        sq1_negate;
  logic [2:0]  sq1_shift;
  logic [1:0]  sq1_duty;
  logic [5:0]  sq1_lenLoad;
  logic        sq1_lenLoadStb;
  logic [3:0]  sq1_startVol;
  logic        sq1_envAdd;
  logic [2:0]  sq1_period;
  logic [10:0] sq1_freq;
  logic        sq1_lenEnable;
  logic        sq1_trigger;
  logic        power;

  always #5 clk = ~clk;

  sq1_reg_decoder dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .rd_en(rd_en), .addr(addr),
    .wdata(wdata), .rdata(rdata), .rvalid(rvalid), .ch1_active(ch1_active),
    .sq1_swpPd(sq1_swpPd), .sq1_negate(sq1_negate), .sq1_shift(sq1_shift),
    .sq1_duty(sq1_duty), .sq1_lenLoad(sq1_lenLoad),
    .sq1_lenLoadStb(sq1_lenLoadStb), .sq1_startVol(sq1_startVol),
    .sq1_envAdd(sq1_envAdd), .sq1_period(sq1_period), .sq1_freq(sq1_freq),
    .sq1_lenEnable(sq1_lenEnable), .sq1_trigger(sq1_trigger), .power(power)
  );

  int checks = 0;
  int failures = 0;

  // Reference model: the raw bytes last accepted for NR10..NR14 plus power.
  logic [7:0] m_reg [5];
  bit         m_power = 1'b1;
  bit         m_trig = 1'b0;
  bit         m_stb = 1'b0;
  bit         m_rvalid = 1'b0;
  bit         mon_en = 1'b0;
  logic [7:0] exp_q [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] model_read(input logic [7:0] a, input bit ch1);
    case (a)
      8'h10:   return 8'h80 | m_reg[0];
      8'h11:   return m_reg[1] | 8'h3F;
      8'h12:   return m_reg[2];
      8'h13:   return 8'hFF;
      8'h14:   return 8'hBF | (m_reg[4] & 8'h40);
      8'h26:   return {m_power, 3'b111, 3'b000, ch1 & m_power};
      default: return 8'hFF;
    endcase
  endfunction

  // Drive one cycle of inputs at the falling edge and advance the model to
  // the state expected just after the following rising edge.
  task automatic step(input bit r, input bit we, input bit re,
                      input logic [7:0] a, input logic [7:0] d, input bit ch1);
    @(negedge clk);
    rst = r; wr_en = we; rd_en = re; addr = a; wdata = d; ch1_active = ch1;
    m_trig = 1'b0;
    m_stb = 1'b0;
    if (r) begin
      for (int i = 0; i < 5; i++) m_reg[i] = 8'h00;
      m_power = 1'b1;
      m_rvalid = 1'b0;
      exp_q.delete();
    end else begin
      m_rvalid = re;
      if (re) exp_q.push_back(model_read(a, ch1));
      if (we) begin
        if (a == 8'h26) begin
          m_power = d[7];
          if (!d[7]) for (int i = 0; i < 5; i++) m_reg[i] = 8'h00;
        end else if (m_power && a >= 8'h10 && a <= 8'h14) begin
          m_reg[a - 8'h10] = d;
          if (a == 8'h11) m_stb = 1'b1;
          if (a == 8'h14) m_trig = d[7];
        end
      end
    end
  endtask

  task automatic settle();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    step(1'b0, 1'b1, 1'b0, a, d, 1'b0);
  endtask

  task automatic rd_lit(input logic [7:0] a, input logic [7:0] exp);
    step(1'b0, 1'b0, 1'b1, a, 8'h00, 1'b0);
    settle();
    check($sformatf("read_%h", a), rdata, exp);
  endtask

  // Monitor: compares every cycle against the model; pops read data on rvalid.
  initial begin
    logic [7:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (mon_en) begin
        check("swpPd",     sq1_swpPd,     m_reg[0][6:4]);
        check("negate",    sq1_negate,    m_reg[0][3]);
        check("shift",     sq1_shift,     m_reg[0][2:0]);
        check("duty",      sq1_duty,      m_reg[1][7:6]);
        check("lenLoad",   sq1_lenLoad,   m_reg[1][5:0]);
        check("startVol",  sq1_startVol,  m_reg[2][7:4]);
        check("envAdd",    sq1_envAdd,    m_reg[2][3]);
        check("period",    sq1_period,    m_reg[2][2:0]);
        check("freq",      sq1_freq,      {m_reg[4][2:0], m_reg[3]});
        check("lenEnable", sq1_lenEnable, m_reg[4][6]);
        check("trigger",   sq1_trigger,   m_trig);
        check("lenLoadStb", sq1_lenLoadStb, m_stb);
        check("power",     power,         m_power);
        check("rvalid",    rvalid,        m_rvalid);
        if (rvalid) begin
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL rdata_unexpected: got %0h with no read pending at %0t", rdata, $time);
          end else begin
            e = exp_q.pop_front();
            check("rdata", rdata, e);
          end
        end
      end
    end
  end

  initial begin
    logic [7:0] addr_pool [9];
    logic [7:0] a;
    addr_pool = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h26, 8'h15, 8'h30, 8'h00};
    for (int i = 0; i < 5; i++) m_reg[i] = 8'h00;

    step(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    mon_en = 1'b1;
    step(1'b1, 1'b1, 1'b1, 8'h14, 8'h80, 1'b0);
    settle();
    check("reset_rdata", rdata, 8'h00);
    check("reset_power", power, 1'b1);
    check("reset_trigger", sq1_trigger, 1'b0);

    rd_lit(8'h10, 8'h80);
    rd_lit(8'h11, 8'h3F);
    rd_lit(8'h12, 8'h00);
    rd_lit(8'h13, 8'hFF);
    rd_lit(8'h14, 8'hBF);
    rd_lit(8'h26, 8'hF0);

    wr(8'h10, 8'h5B);
    wr(8'h11, 8'hC5);
    settle();
    check("stb_after_nr11", sq1_lenLoadStb, 1'b1);
    wr(8'h12, 8'hA3);
    settle();
    check("stb_one_cycle", sq1_lenLoadStb, 1'b0);
    check("plan_swpPd", sq1_swpPd, 3'd5);
    check("plan_shift", sq1_shift, 3'd3);
    check("plan_duty", sq1_duty, 2'd3);
    check("plan_lenLoad", sq1_lenLoad, 6'd5);
    check("plan_startVol", sq1_startVol, 4'd10);
    check("plan_period", sq1_period, 3'd3);

    wr(8'h13, 8'h34);
    wr(8'h14, 8'hC6);
    settle();
    check("plan_trigger", sq1_trigger, 1'b1);
    check("plan_freq", sq1_freq, 11'h634);
    check("plan_lenEnable", sq1_lenEnable, 1'b1);
    wr(8'h14, 8'h46);
    settle();
    check("plan_no_trigger", sq1_trigger, 1'b0);
    check("plan_freq_same", sq1_freq, 11'h634);
    wr(8'h14, 8'h86);
    wr(8'h14, 8'h86);
    settle();
    check("b2b_trigger", sq1_trigger, 1'b1);

    wr(8'h26, 8'h00);
    settle();
    check("pwroff_freq", sq1_freq, 11'h000);
    check("pwroff_swpPd", sq1_swpPd, 3'd0);
    wr(8'h12, 8'hF0);
    settle();
    check("pwroff_ignored", sq1_startVol, 4'd0);
    rd_lit(8'h26, 8'h70);
    wr(8'h26, 8'h80);
    wr(8'h12, 8'hF0);
    settle();
    check("pwron_startVol", sq1_startVol, 4'd15);

    wr(8'h12, 8'hA3);
    step(1'b0, 1'b1, 1'b1, 8'h12, 8'h10, 1'b0);
    settle();
    check("rw_same_cycle", rdata, 8'hA3);
    rd_lit(8'h12, 8'h10);

    rd_lit(8'h15, 8'hFF);
    rd_lit(8'h30, 8'hFF);
    wr(8'h15, 8'h55);
    wr(8'h30, 8'hAA);
    settle();
    check("unmapped_startVol", sq1_startVol, 4'd1);

    wr(8'h13, 8'h77);
    step(1'b1, 1'b1, 1'b0, 8'h14, 8'h87, 1'b0);
    settle();
    check("rst_trigger", sq1_trigger, 1'b0);
    check("rst_freq", sq1_freq, 11'h000);
    step(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);

    for (int n = 0; n < 800; n++) begin
      a = ($urandom_range(0, 9) == 0) ? 8'($urandom) : addr_pool[$urandom_range(0, 8)];
      step(($urandom_range(0, 60) == 0), $urandom_range(0, 1) == 1,
           $urandom_range(0, 1) == 1, a, 8'($urandom), $urandom_range(0, 1) == 1);
    end

    step(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    step(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    settle();
    check("reads_drained", exp_q.size(), 0);
    mon_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
